quad_input_filter: RTL and testbench
====================================

// Module: quad_input_filter
// PURPOSE
//   Front-end conditioning for the incremental encoder lines A, B, C (index).
//   Synchronises raw pins to clk and rejects glitches with a per-channel
//   stability counter. Flags illegal quadrature steps (A and B change together).
//   Sits between the encoder pins and quad_sensor_core: cA/cB/cC feed its
//   cA/cB/cC inputs; ~ready drives its rst.
// PARAMETERS
//   FILT_LEN  8   consecutive clocks a new level must persist to be accepted; legal 1..255
//   ERR_W     16  width of the illegal-step counter
// PORTS
//   clk      in   1      system clock
//   rst      in   1      synchronous reset, active-high
//   iA       in   1      raw encoder channel A (asynchronous)
//   iB       in   1      raw encoder channel B (asynchronous)
//   iC       in   1      raw index channel C (asynchronous)
//   clr_err  in   1      synchronous clear of err_cnt
//   cA       out  1      filtered A
//   cB       out  1      filtered B
//   cC       out  1      filtered C (see CONFIGURATION)
//   ready    out  1      outputs valid since reset; low during start-up fill
//   err      out  1      one-clock pulse on an illegal A+B step
//   err_cnt  out  ERR_W  saturating count of illegal steps
// BEHAVIOUR
//   Interface: one clock; rst is synchronous and active-high; all state updates on posedge clk.
//   Reset: sync regs, cA, cB, cC, err, ready = 0; err_cnt = 0; all filter counters = 0; start counter = 0.
//   Sync: per channel 2-FF chain s1 <= iX, s2 <= s1. No logic between s1 and s2.
//   Filter: 8-bit cnt per channel; each edge:
//     - s2 == out: cnt <= 0.
//     - s2 != out and cnt == FILT_LEN-1: out <= s2, cnt <= 0.
//     - otherwise: cnt <= cnt+1.
//   Latency: a clean level change first captured into s1 on edge 1 appears on the output at edge FILT_LEN+2.
//   Rejection: a pulse at s2 shorter than FILT_LEN clocks never reaches the output; its counter returns to 0.
//   Start-up: the start counter counts edges after reset release. ready <= 1 when it reaches FILT_LEN+2, then holds.
//     While ready = 0, outputs still track the filtered inputs. This lets them settle to pin levels before downstream leaves reset.
//   Illegal step: on an edge where cA and cB both update, err <= 1 for one clock. Condition applies only while ready = 1.
//     Otherwise err <= 0.
//   err_cnt: increments on each err pulse and saturates at all-ones.
//     clr_err = 1 forces err_cnt <= 0 and takes priority over an increment on the same edge.
//     err still pulses on that edge.
//   C has no step check; its changes never set err.
//   rst mid-operation: everything returns to reset values on the next edge and ready drops.
//     Any partially counted glitch is discarded.
// CONFIGURATION
//   QUAD_FILT_INDEX_GATE_EN defined:
//     - Filtered C is presented as cC only while filtered cA = 1 and cB = 1.
//     - cC = cC_filt & cA & cB, registered, so cC lags the filtered C by one extra clock.
//   QUAD_FILT_INDEX_GATE_EN undefined:
//     - cC = filtered C directly, with no extra register and no gating.
//     - C latency equals A/B latency.
// TESTING
//   1. Reset, FILT_LEN=8, pins held 1 -> ready rises at edge 10 after rst release; cA=cB=cC=1 by then; err_cnt=0.
//   2. iA steps 0->1, held -> cA changes exactly 10 edges after the step is sampled; cB, err unchanged.
//   3. iB glitch of 7 clocks -> cB never changes. Glitch of 8 clocks -> cB toggles once, then returns after 8 more stable clocks.
//   4. iA and iB toggled on the same clock, ready=1 -> one-clock err pulse; err_cnt 0->1.
//      Repeat with clr_err asserted on the update edge -> err pulses, err_cnt=0.
//   5. Force err_cnt to 0xFFFF via 65535 illegal steps, then one more -> err_cnt stays 0xFFFF.
//   6. GATE_EN defined: iC pulse with A=1, B=0 -> cC stays 0. Same pulse with A=B=1 -> cC=1, one clock later than ungated build.

Source files
------------

// File: rtl/quad_input_filter.sv
// Encoder pin conditioning: 2-FF sync, per-channel stability filter, start-up ready, illegal A+B step detection.
// Optional QUAD_FILT_INDEX_GATE_EN: cC is registered and gated with filtered A and B.
module quad_input_filter #(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iA,
  input  logic             iB,
  input  logic             iC,
  input  logic             clr_err,
  output logic             cA,
  output logic             cB,
  output logic             cC,
  output logic             ready,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [7:0]       CNT_LAST   = 8'(FILT_LEN - 1);
  localparam logic [8:0]       START_DONE = 9'(FILT_LEN + 2);
  localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

  // Channel index: 0 = A, 1 = B, 2 = C
  logic [2:0]       s1_q, s2_q;
  logic [2:0]       filt_q, filt_d;
  logic [7:0]       cnt_q [3];
  logic [7:0]       cnt_d [3];
  logic [8:0]       start_q, start_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = s2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end

    start_d = start_q;
    ready_d = ready_q;
    if (!ready_q) begin
      start_d = start_q + 9'd1;
      if (start_d == START_DONE) ready_d = 1'b1;
    end

    // An accepted level always differs from the old one, so a change marks an update
    err_d = ready_q && (filt_d[0] != filt_q[0]) && (filt_d[1] != filt_q[1]);

    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      filt_q    <= '0;
      start_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= {iC, iB, iA};
      s2_q      <= s1_q;
      filt_q    <= filt_d;
      start_q   <= start_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef QUAD_FILT_INDEX_GATE_EN
  logic cc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= 1'b0;
    end else begin
      cc_q <= filt_q[2] & filt_q[0] & filt_q[1];
    end
  end

  assign cC = cc_q;
`else
  assign cC = filt_q[2];
`endif

  assign cA      = filt_q[0];
  assign cB      = filt_q[1];
  assign ready   = ready_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_input_filter.sv
// Scoreboard bench for quad_input_filter: a per-edge reference model pushes expected outputs,
// a negedge monitor pops and compares. Small ERR_W keeps counter saturation reachable.
module tb_quad_input_filter;

  localparam int unsigned FL = 8;
  localparam int unsigned EW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    pin_v = 3'b111;
  logic          clr_err = 1'b0;
  logic          cA, cB, cC, ready, err;
  logic [EW-1:0] err_cnt;

  quad_input_filter #(.FILT_LEN(FL), .ERR_W(EW)) dut (
    .clk     (clk),
    .rst     (rst),
    .iA      (pin_v[0]),
    .iB      (pin_v[1]),
    .iC      (pin_v[2]),
    .clr_err (clr_err),
    .cA      (cA),
    .cB      (cB),
    .cC      (cC),
    .ready   (ready),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          a;
    logic          b;
    logic          c;
    logic          rdy;
    logic          e;
    logic [EW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a level is accepted once the synchronised pin has disagreed with
  // the output for FL consecutive edges, i.e. FL edges after it last agreed.
  logic [2:0]    pin_hist[$];
  logic [2:0]    out_m = '0;
  logic [EW-1:0] cnt_m = '0;
  logic          gate_m = 1'b0;
  int            k = 0;
  int            last_eq[3];

  always @(posedge clk) begin
    exp_t       e;
    logic [2:0] s2;
    logic [2:0] new_out;
    logic [2:0] upd;
    logic       rdy_before;
    logic       err_m;
    if (rst) begin
      pin_hist.delete();
      out_m  = '0;
      cnt_m  = '0;
      gate_m = 1'b0;
      k      = 0;
      for (int i = 0; i < 3; i++) last_eq[i] = 0;
      e = '0;
    end else begin
      k  = k + 1;
      s2 = (pin_hist.size() >= 2) ? pin_hist[0] : 3'b000;
      pin_hist.push_back(pin_v);
      if (pin_hist.size() > 2) void'(pin_hist.pop_front());
      rdy_before = ((k - 1) >= int'(FL + 2));
      new_out = out_m;
      upd = '0;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == out_m[i]) begin
          last_eq[i] = k;
        end else if (k - last_eq[i] >= int'(FL)) begin
          new_out[i] = s2[i];
          upd[i] = 1'b1;
          last_eq[i] = k;
        end
      end
      err_m = rdy_before && upd[0] && upd[1];
      if (clr_err) cnt_m = '0;
      else if (err_m && (int'(cnt_m) < (1 << EW) - 1)) cnt_m = cnt_m + 1'b1;
      gate_m = out_m[2] & out_m[1] & out_m[0];
      out_m  = new_out;
      e.a   = out_m[0];
      e.b   = out_m[1];
`ifdef QUAD_FILT_INDEX_GATE_EN
      e.c   = gate_m;
`else
      e.c   = out_m[2];
`endif
      e.rdy = (k >= int'(FL + 2));
      e.e   = err_m;
      e.cnt = cnt_m;
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t exp_v;
    exp_t act_v;
    act_v = {cA, cB, cC, ready, err, err_cnt};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t: actual {cA,cB,cC,ready,err,err_cnt}=%b, no expected entry", $time, act_v);
    end else begin
      exp_v = sb.pop_front();
      if (act_v !== exp_v)  begin
        errors++;
        $display("FAIL outputs at %0t: actual {cA,cB,cC,ready,err,err_cnt}=%b required %b", $time, act_v, exp_v);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hold[3];
    // start-up with pins high
    rst = 1'b1; pin_v = 3'b111; clr_err = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(15);
    // clean step on A
    pin_v[0] = 1'b0; cyc(14);
    // B glitches of FL-1 and FL clocks
    pin_v[1] = 1'b0; cyc(FL - 1); pin_v[1] = 1'b1; cyc(14);
    pin_v[1] = 1'b0; cyc(FL);     pin_v[1] = 1'b1; cyc(20);
    // illegal steps, second one under clr_err
    pin_v[0] = 1'b1; pin_v[1] = 1'b0; cyc(14);
    clr_err = 1'b1;
    pin_v[0] = 1'b0; pin_v[1] = 1'b1; cyc(14);
    clr_err = 1'b0;
    // drive err_cnt into saturation
    for (int i = 0; i < (1 << EW) + 4; i++) begin
      pin_v[0] = ~pin_v[0]; pin_v[1] = ~pin_v[1]; cyc(12);
    end
    // index pulses with A=1,B=0 then A=B=1
    pin_v = 3'b001; cyc(14);
    pin_v[2] = 1'b1; cyc(12); pin_v[2] = 1'b0; cyc(12);
    pin_v[1] = 1'b1; cyc(14);
    pin_v[2] = 1'b1; cyc(12); pin_v[2] = 1'b0; cyc(14);
    // reset in the middle of a partially counted change
    pin_v[0] = ~pin_v[0]; cyc(5);
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(16);
    // randomized run lengths around the filter length
    for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 2 * FL + 2);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        pin_v[0] = ~pin_v[0];
        pin_v[1] = ~pin_v[1];
        hold[0] = $urandom_range(FL, 2 * FL + 2);
        hold[1] = hold[0];
      end
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          pin_v[i] = ~pin_v[i];
          hold[i] = $urandom_range(1, 2 * FL + 2);
        end else begin
          hold[i]--;
        end
      end
      clr_err = ($urandom_range(0, 29) == 0);
      rst     = ($urandom_range(0, 799) == 0);
    end
    rst = 1'b0; clr_err = 1'b0;
    cyc(4);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
